// File: rtl/aes_inv_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_round_ctrl
// Brief   : Sequencer for the AES-128 inverse-cipher datapath. It runs the
//           initial AddRoundKey, NR-1 full inverse rounds and the final round.
// Rev     : 1.0  initial release
// ============================================================================
module aes_inv_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          key_ready,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          in_load,
    output logic          st_load,
    output logic          rnd_en,
    output logic          last_rnd,
    output logic [RW-1:0] rk_sel,
    output logic [RW-1:0] rnd,
    output logic          busy,
    output logic [CW-1:0] blk_cnt,
    output logic          abort_p
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_INIT  = 3'd1;
    localparam logic [2:0] c_ROUND = 3'd2;
    localparam logic [2:0] c_FINAL = 3'd3;
    localparam logic [2:0] c_HOLD  = 3'd4;

    localparam logic [RW-1:0] c_NR   = RW'(NR);
    localparam logic [RW-1:0] c_LAST = RW'(NR - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nx;
    logic [RW-1:0] w_rnd_nx;
    logic [RW-1:0] w_rk_nx;
    logic          w_cnt_inc;
    logic          w_abort_nx;

    // RST_N gates the combinational handshake so it reads 0 while in reset.
    assign in_ready = RST_N & key_ready & ~flush &
                      ((r_state == c_IDLE) | ((r_state == c_HOLD) & out_ready));
    assign in_load  = in_valid & in_ready;

    always_comb begin
        w_state_nx = r_state;
        w_rnd_nx   = rnd;
        w_rk_nx    = rk_sel;
        w_cnt_inc  = 1'b0;
        w_abort_nx = 1'b0;
        if (flush && (r_state != c_IDLE)) begin
            w_state_nx = c_IDLE;
            w_rnd_nx   = '0;
            w_rk_nx    = '0;
            w_abort_nx = 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_rnd_nx = '0;
                    w_rk_nx  = '0;
                    if (in_load) w_state_nx = c_INIT;
                end
                c_INIT: begin
                    w_state_nx = c_ROUND;
                    w_rnd_nx   = RW'(1);
                    w_rk_nx    = RW'(1);
                end
                c_ROUND: begin
                    if (rnd == c_LAST) begin
                        w_state_nx = c_FINAL;
                        w_rnd_nx   = c_NR;
                        w_rk_nx    = c_NR;
                    end else begin
                        w_rnd_nx = rnd + RW'(1);
                        w_rk_nx  = rnd + RW'(1);
                    end
                end
                c_FINAL: begin
                    w_state_nx = c_HOLD;
                end
                c_HOLD: begin
                    // rk_sel/rnd stay frozen at NR while the consumer stalls.
                    if (out_ready) begin
                        w_cnt_inc  = 1'b1;
                        w_state_nx = in_load ? c_INIT : c_IDLE;
                        w_rnd_nx   = '0;
                        w_rk_nx    = '0;
                    end
                end
                default: begin
                    w_state_nx = c_IDLE;
                    w_rnd_nx   = '0;
                    w_rk_nx    = '0;
                end
            endcase
        end
    end

    // Strobes are decoded from the next state so they line up with it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= c_IDLE;
            rnd       <= '0;
            rk_sel    <= '0;
            st_load   <= 1'b0;
            rnd_en    <= 1'b0;
            last_rnd  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            abort_p   <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            r_state   <= w_state_nx;
            rnd       <= w_rnd_nx;
            rk_sel    <= w_rk_nx;
            st_load   <= (w_state_nx == c_INIT);
            rnd_en    <= (w_state_nx == c_ROUND) || (w_state_nx == c_FINAL);
            last_rnd  <= (w_state_nx == c_FINAL);
            out_valid <= (w_state_nx == c_HOLD);
            busy      <= (w_state_nx == c_INIT) || (w_state_nx == c_ROUND) ||
                         (w_state_nx == c_FINAL);
            abort_p   <= w_abort_nx;
            if (w_cnt_inc) blk_cnt <= blk_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/aes_inv_round_ctrl.md
Name: aes_inv_round_ctrl

Overview:
- Sequencer for the AES-128 inverse-cipher datapath. Accepts one ciphertext block per valid/ready handshake and steps the datapath through the initial AddRoundKey, nine full inverse rounds and one final round.
- Drives the per-cycle control strobes: input load, state load, round enable, round-key slice select and last-round bypass.
- Returns the plaintext-valid handshake to the consumer.
- Sits between the block source and the inverse-cipher datapath; the expanded key schedule comes from the key-expansion block, which raises key_ready when its schedule is stable.

Parameters:
- NR, 10, number of cipher rounds (AES-128); rk_sel ranges 0..NR.
- RW, 4, width of the round index and of rk_sel; must satisfy 2^RW > NR.
- CW, 16, width of the completed-block counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- in_valid  input  1  ciphertext block presented.
- in_ready  output  1  controller can accept a block this cycle.
- key_ready  input  1  expanded key schedule is valid and stable.
- flush  input  1  synchronous abort of the block in flight.
- out_valid  output  1  plaintext held in the datapath output register.
- out_ready  input  1  consumer takes the plaintext.
- in_load  output  1  datapath latches the input block (handshake cycle).
- st_load  output  1  datapath state <= input ^ round key rk_sel (initial AddRoundKey).
- rnd_en  output  1  datapath state <= one inverse round using round key rk_sel.
- last_rnd  output  1  with rnd_en: skip InvMixColumns and load the output register.
- rk_sel  output  RW  index of the 128-bit round-key slice in the schedule; slice k is bits [128k+127:128k].
- rnd  output  RW  current round number, for debug/visibility.
- busy  output  1  a block is in flight (INIT..FINAL).
- blk_cnt  output  CW  number of blocks delivered; wraps modulo 2^CW.
- abort_p  output  1  one-cycle pulse when flush kills an in-flight or held block.

Behaviour:
- Reset (RST_N low, asynchronous) forces state IDLE and drives these values:
  - in_ready=0, out_valid=0, in_load=0, st_load=0, rnd_en=0, last_rnd=0
  - rk_sel=0, rnd=0, busy=0, blk_cnt=0, abort_p=0
  - Reset deassertion is synchronised by the integrator; the block assumes a clean release.
- States: IDLE, INIT, ROUND, FINAL, HOLD.
- Accept condition: in_ready = key_ready & !flush & (IDLE | (HOLD & out_ready)). A handshake is in_valid & in_ready.
  - in_load=1 in the handshake cycle, combinationally.
  - The next state is INIT.
- IDLE: rk_sel=0 and rnd=0. The state is held until a handshake occurs.
- INIT (1 cycle): st_load=1, rk_sel=0, busy=1. Next state is ROUND with rnd=1.
- ROUND (NR-1 cycles): rnd_en=1, rk_sel=rnd, busy=1.
  - rnd increments each cycle.
  - When rnd=NR-1 the next state is FINAL.
- FINAL (1 cycle): rnd_en=1, last_rnd=1, rk_sel=NR, rnd=NR, busy=1. Next state is HOLD.
- HOLD: out_valid=1 until out_ready is high. On that cycle blk_cnt increments by 1.
  - With a simultaneous handshake: next state is INIT (back-to-back operation).
  - Without one: next state is IDLE.
- Latency: handshake at cycle T gives INIT at T+1, ROUND 1..9 at T+2..T+10, FINAL at T+11 and out_valid at T+12.
  - Sustained throughput is one block per 12 cycles when out_ready is held high.
- Strobe exclusivity: st_load, rnd_en and out_valid are mutually exclusive. last_rnd is asserted only together with rnd_en.
- key_ready is sampled only for acceptance.
  - If it falls during INIT/ROUND/FINAL, the block completes normally.
  - The key-expansion block must not change the schedule while busy=1.
- flush (synchronous, highest priority after reset):
  - In INIT/ROUND/FINAL/HOLD: next state is IDLE, abort_p=1 for one cycle, out_valid drops the next cycle and blk_cnt is unchanged.
  - In IDLE: no effect and no pulse.
  - in_ready is 0 while flush=1.
- out_valid stability: once asserted, out_valid stays high until out_ready or flush, and the datapath output register is not reloaded while it is high.
- in_valid in any state other than IDLE or HOLD is ignored; the source holds the block.
- blk_cnt wraps from 2^CW-1 to 0 with no flag.
- rk_sel never exceeds NR. Outputs are registered except in_ready and in_load, which are combinational from the state and inputs.

Test Plan:
- Single block: reset, key_ready=1, in_valid pulse at T.
  - in_load at T, st_load at T+1, rnd_en at T+2..T+11 with rk_sel 1..10.
  - last_rnd only at T+11; out_valid at T+12.
  - With out_ready=1 at T+12: blk_cnt=1 and state returns to IDLE.
- Back-to-back: in_valid and out_ready held at 1 with 3 blocks.
  - Handshakes at T, T+12, T+24; out_valid at T+12, T+24, T+36.
  - blk_cnt=3; in_ready is never high during busy.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises.
  - out_valid stays 1, in_ready=0, no strobes, rk_sel frozen.
  - Release gives blk_cnt+1 in that cycle.
- Key gating:
  - key_ready=0 with in_valid=1: in_ready stays 0 and there is no in_load.
  - key_ready dropped at T+5 of a block: completion at T+12 is unaffected.
- Flush: assert at T+6, and separately during HOLD.
  - abort_p=1 for one cycle, state IDLE next cycle, out_valid=0, blk_cnt unchanged.
  - Next accept works normally.
- Async reset at T+7: all outputs reach their reset values without a clock edge. After release, a new block completes in 12 cycles.
